// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver sampling an async line on an oversampling tick, with ready/read handshake.
// Optional even-parity bit between data and stop: define RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             sh_q, sh_d;
  logic [7:0]             dout_q, dout_d;
  logic                   rdy_q, rdy_d;
  logic                   ovr_q, ovr_d;
  logic                   fe_q, fe_d;
  logic                   done;
  logic                   par_ok;
`ifdef RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;
`endif

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RX_PARITY_EN
  assign par_ok = ~(^{sh_q, par_q});
`else
  assign par_ok = 1'b1;
`endif

  // Frame FSM: only moves on tick; pulses default low every clk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    fe_d    = 1'b0;
    done    = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            sh_d  = {rx_s, sh_q[7:1]};
            cnt_d = '0;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s;
            cnt_d   = '0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            state_d = IDLE;
            cnt_d   = '0;
            fe_d    = ~rx_s;
`ifdef RX_PARITY_EN
            pe_d    = ~par_ok;
`endif
            done    = rx_s & par_ok;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake: a completion in the same cycle as rd wins over the clear.
  always_comb begin
    dout_d = dout_q;
    rdy_d  = rdy_q;
    ovr_d  = ovr_q;
    if (done) begin
      dout_d = sh_q;
      rdy_d  = 1'b1;
      if (rd)         ovr_d = 1'b0;
      else if (rdy_q) ovr_d = 1'b1;
    end else if (rd) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
`ifdef RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_ready = rdy_q;
  assign overrun    = ovr_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);
`ifdef RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: glitch, normal byte, framing, overrun,
// rd/completion collision, reset mid-frame, half-rate tick, and parity when enabled.
module tb_uart_rx_oversampled;
  localparam int OS = 16;
`ifdef RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // 2 sync stages + 1 idle-detect edge + 8 start ticks + 8*16 data + 16 stop.
  localparam int LAT = 3 + OS/2 + 8*OS + (NBITS - 9)*OS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rd  = 1'b0;
  logic tick;
  logic half_rate = 1'b0;
  logic tick_ph   = 1'b0;
  logic [7:0] data_out;
  logic data_ready, frame_err, overrun, busy;
`ifdef RX_PARITY_EN
  logic parity_err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic rdy_prev = 1'b0;
  int bit_clks = OS;
  int t0, fe0, pe0;

  uart_rx_oversampled #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx), .rd(rd),
    .data_out(data_out), .data_ready(data_ready), .frame_err(frame_err),
    .overrun(overrun),
`ifdef RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    tick_ph <= ~tick_ph;
  end
  assign tick = half_rate ? tick_ph : 1'b1;

  always @(negedge clk) begin
    rdy_prev <= data_ready;
    if (data_ready && !rdy_prev) rise_cyc <= cyc;
    if (frame_err) fe_cnt <= fe_cnt + 1;
`ifdef RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (bit_clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    logic [10:0] f;
    if (NBITS == 11) f = {stop_b, (^d) ^ bad_par, d, 1'b0};
    else             f = {1'b1, stop_b, d, 1'b0};
    for (int i = 0; i < NBITS; i++) send_bit(f[i]);
    rx = 1'b1;
  endtask

  task automatic pulse_rd;
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    idle(5);

    // glitch: 5 low ticks is shorter than half a bit
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    chk("glitch_busy_hi", busy, 1'b1);
    idle(20);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_ready", data_ready, 1'b0);
    chk("glitch_data", data_out, 8'h00);

    // normal byte
    fe0 = fe_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_latency", rise_cyc - t0, LAT);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_ready", data_ready, 1'b1);
    chk("a5_busy", busy, 1'b0);
    chk("a5_overrun", overrun, 1'b0);
    chk("a5_no_fe", fe_cnt - fe0, 0);
    pulse_rd;
    chk("rd_clear", data_ready, 1'b0);
    chk("rd_keeps_data", data_out, 8'hA5);
    pulse_rd;
    chk("rd_idle_ready", data_ready, 1'b0);
    chk("rd_idle_ovr", overrun, 1'b0);

    // framing error
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(30);
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_ready", data_ready, 1'b0);
    chk("fe_data", data_out, 8'hA5);
    chk("fe_busy", busy, 1'b0);

    // overrun with back-to-back frames
    send_frame(8'h11, 1'b1, 1'b0);
    chk("ovr_first_data", data_out, 8'h11);
    chk("ovr_first_flag", overrun, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_data", data_out, 8'h22);
    chk("ovr_ready", data_ready, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    pulse_rd;
    chk("ovr_rd_ready", data_ready, 1'b0);
    chk("ovr_rd_flag", overrun, 1'b0);

    // rd in the completion cycle: completion wins, no overrun
    send_frame(8'h44, 1'b1, 1'b0);
    fork
      send_frame(8'h33, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    chk("coll_data", data_out, 8'h33);
    chk("coll_ready", data_ready, 1'b1);
    chk("coll_ovr", overrun, 1'b0);
    pulse_rd;

    // reset during data bit 4 of 0x5A
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(8'h5A >> i);
    rx = 1'b1;
    idle(8);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    rx = 1'b1;
    idle(120);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ready", data_ready, 1'b0);
    chk("rstmid_data", data_out, 8'h00);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("rstmid_c3_data", data_out, 8'hC3);
    chk("rstmid_c3_ready", data_ready, 1'b1);
    pulse_rd;

    // tick at half the clock rate
    half_rate = 1'b1;
    bit_clks = 2*OS;
    idle(4);
    send_frame(8'h96, 1'b1, 1'b0);
    chk("half_data", data_out, 8'h96);
    chk("half_ready", data_ready, 1'b1);
    chk("half_busy", busy, 1'b0);
    half_rate = 1'b0;
    bit_clks = OS;
    pulse_rd;
    idle(4);

`ifdef RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_ok_data", data_out, 8'h07);
    chk("par_ok_ready", data_ready, 1'b1);
    pulse_rd;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(5);
    chk("par_err_pulses", pe_cnt - pe0, 1);
    chk("par_err_ready", data_ready, 1'b0);
    chk("par_err_data", data_out, 8'h07);
`else
    pe0 = pe_cnt;
    chk("no_parity_pulses", pe_cnt - pe0 + {31'd0, data_ready}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
